reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 18 +
 rtl/rf_read_port.sv | 38 +++
 rtl/reg_file.sv | 63 ++++++
 tb/tb_reg_file.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// ============================================================================
// Module      : reg_file_pkg
// Description : Shared constants and types for the integer register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_file_pkg;

    localparam int unsigned RF_NUM_REGS = 32;
    localparam int unsigned RF_ADDR_W   = 5;
    localparam int unsigned XLEN        = 32;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;

endpackage : reg_file_pkg

`default_nettype wire

// File: rtl/rf_read_port.sv
// ============================================================================
// Module      : rf_read_port
// Description : One asynchronous read port: x0 check, array select and, when
//               RF_WR_BYPASS_EN is defined, a write-first bypass mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_read_port
    import reg_file_pkg::*;
(
    input  rf_addr_t         addr_i,
    input  logic [XLEN-1:0]  regs_i [1:RF_NUM_REGS-1],
`ifdef RF_WR_BYPASS_EN
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  rf_addr_t         wr_reg_i,
    input  logic [XLEN-1:0]  wr_data_i,
`endif
    output logic [XLEN-1:0]  data_oa
);

    always_comb begin
        data_oa = '0;
        if (addr_i != '0) begin
            data_oa = regs_i[addr_i];
`ifdef RF_WR_BYPASS_EN
            // Reset drops the write, so the forwarded value must not leak out.
            if (!rst_i && wr_en_i && (wr_reg_i == addr_i)) begin
                data_oa = wr_data_i;
            end
`endif
        end
    end

endmodule : rf_read_port

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
// Module      : reg_file
// Description : 31 x 32-bit register file (x0 hard-wired to zero), one write
//               port and two asynchronous read ports. Define RF_WR_BYPASS_EN
//               for write-first reads; otherwise reads are read-first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file
    import reg_file_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rf_wr_en_i,
    input  rf_addr_t         rf_wr_reg_i,
    input  logic [XLEN-1:0]  rf_wr_data_i,
    input  rf_addr_t         rs1_addr_i,
    input  rf_addr_t         rs2_addr_i,
    output logic [XLEN-1:0]  rs1_data_oa,
    output logic [XLEN-1:0]  rs2_data_oa
);

    // x0 has no storage; the array starts at index 1.
    logic [XLEN-1:0] r_regs [1:RF_NUM_REGS-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 1; i < RF_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (rf_wr_en_i && (rf_wr_reg_i != '0)) begin
            r_regs[rf_wr_reg_i] <= rf_wr_data_i;
        end
    end

    rf_read_port u_rs1_port (
        .addr_i    (rs1_addr_i),
        .regs_i    (r_regs),
`ifdef RF_WR_BYPASS_EN
        .rst_i     (rst_i),
        .wr_en_i   (rf_wr_en_i),
        .wr_reg_i  (rf_wr_reg_i),
        .wr_data_i (rf_wr_data_i),
`endif
        .data_oa   (rs1_data_oa)
    );

    rf_read_port u_rs2_port (
        .addr_i    (rs2_addr_i),
        .regs_i    (r_regs),
`ifdef RF_WR_BYPASS_EN
        .rst_i     (rst_i),
        .wr_en_i   (rf_wr_en_i),
        .wr_reg_i  (rf_wr_reg_i),
        .wr_data_i (rf_wr_data_i),
`endif
        .data_oa   (rs2_data_oa)
    );

endmodule : reg_file

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
// Module      : tb_reg_file
// Description : Scoreboard bench for reg_file; directed scenarios followed by
//               random traffic, compared against an array model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file;

`ifdef RF_WR_BYPASS_EN
    localparam bit c_bypass = 1'b1;
`else
    localparam bit c_bypass = 1'b0;
`endif

    logic        clk;
    logic        rst_i;
    logic        rf_wr_en_i;
    logic [4:0]  rf_wr_reg_i;
    logic [31:0] rf_wr_data_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic [31:0] rs1_data_oa;
    logic [31:0] rs2_data_oa;

    reg_file dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .rf_wr_en_i   (rf_wr_en_i),
        .rf_wr_reg_i  (rf_wr_reg_i),
        .rf_wr_data_i (rf_wr_data_i),
        .rs1_addr_i   (rs1_addr_i),
        .rs2_addr_i   (rs2_addr_i),
        .rs1_data_oa  (rs1_data_oa),
        .rs2_data_oa  (rs2_data_oa)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
        int          id;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model [32];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          done     = 1'b0;

    // Architectural view: x0 reads zero, a same-cycle non-reset write is
    // visible only in the write-first build.
    function automatic logic [31:0] predict(input logic [4:0] a, input bit r,
                                            input bit we, input logic [4:0] wr,
                                            input logic [31:0] wd);
        if (a == 5'd0) return 32'h0;
        if (c_bypass && !r && we && wr == a) return wd;
        return model[a];
    endfunction

    task automatic cycle(input bit r, input bit we, input logic [4:0] wr,
                         input logic [31:0] wd, input logic [4:0] a1,
                         input logic [4:0] a2, input bit chk, input int id);
        exp_t e;
        @(posedge clk);
        #1;
        rst_i = r; rf_wr_en_i = we; rf_wr_reg_i = wr; rf_wr_data_i = wd;
        rs1_addr_i = a1; rs2_addr_i = a2;
        if (chk) begin
            e.a1 = a1; e.a2 = a2; e.id = id;
            e.e1 = predict(a1, r, we, wr, wd);
            e.e2 = predict(a2, r, we, wr, wd);
            sb_q.push_back(e);
        end
        if (r) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (we && wr != 5'd0) begin
            model[wr] = wd;
        end
    endtask

    // Monitor: outputs are combinational, so each driven cycle presents one
    // response, sampled on the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_checks++;
            if (rs1_data_oa !== e.e1) begin
                n_fail++;
                $display("FAIL rs1 id=%0d addr=%0d got=%h exp=%h", e.id, e.a1, rs1_data_oa, e.e1);
            end
            n_checks++;
            if (rs2_data_oa !== e.e2) begin
                n_fail++;
                $display("FAIL rs2 id=%0d addr=%0d got=%h exp=%h", e.id, e.a2, rs2_data_oa, e.e2);
            end
        end
    end

    initial begin
        rst_i = 1'b1; rf_wr_en_i = 1'b0; rf_wr_reg_i = '0; rf_wr_data_i = '0;
        rs1_addr_i = '0; rs2_addr_i = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        // Reset clear; the first cycle is unchecked since state is unknown.
        cycle(1, 0, 0, 0, 5, 31, 0, 0);
        cycle(0, 0, 0, 0, 5, 31, 1, 1);
        // A checked reset cycle: outputs stay zero while reset is held.
        cycle(1, 0, 0, 0, 5, 31, 1, 2);
        cycle(0, 0, 0, 0, 31, 5, 1, 3);

        // Basic write then read on both ports.
        cycle(0, 1, 7, 32'hDEADBEEF, 7, 7, 1, 10);
        cycle(0, 0, 0, 0, 7, 7, 1, 11);

        // x0 protection.
        cycle(0, 1, 0, 32'hFFFFFFFF, 0, 0, 1, 20);
        cycle(0, 0, 0, 0, 0, 7, 1, 21);
        cycle(0, 0, 0, 0, 1, 31, 1, 22);

        // Same-cycle hazard.
        cycle(0, 1, 3, 32'h11, 0, 0, 1, 30);
        cycle(0, 1, 3, 32'h22, 3, 3, 1, 31);
        cycle(0, 0, 0, 0, 3, 3, 1, 32);

        // Reset versus write: reset wins and no bypass escapes.
        cycle(1, 1, 9, 32'h5A, 9, 9, 1, 40);
        cycle(0, 0, 0, 0, 9, 7, 1, 41);

        // Back-to-back writes x1..x31, reading while writing.
        for (int i = 1; i < 32; i++) begin
            cycle(0, 1, 5'(i), 32'(i * 3), 5'(i), 5'(i - 1), 1, 100 + i);
        end
        cycle(0, 0, 5, 32'hCAFEF00D, 5, 5, 1, 140);
        for (int i = 0; i < 32; i++) begin
            cycle(0, 0, 0, 0, 5'(i), 5'(31 - i), 1, 150 + i);
        end

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 39) == 0), $urandom_range(0, 1),
                  5'($urandom), $urandom, 5'($urandom), 5'($urandom), 1, 1000 + n);
        end

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d exp=0", sb_q.size());
        end
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_file

`default_nettype wire
